fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that produces `instr`/`PC` for the decode stage and consumes decode's redirect (`flush`, `willBranch`, `nextPC`) and back-pressure (`stall`).
- Talks to a variable-latency instruction memory through a request/ready/response handshake, with at most one request in flight.
- Fetched words queue in a small in-order buffer so memory latency and decode stalls are decoupled.
- Drives `fetch_stall` (bubble indicator) and a NOP whenever no instruction is available.

Parameters:
- BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2)
- RESET_PC, 16'h0000, PC loaded at reset
- NOP_INSTR, 16'h0800, word presented to decode during bubbles (opcode 00001)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request valid
- imem_addr  out  16  fetch address (the PC being fetched)
- imem_ready  in  1  memory accepts request this cycle (transfer = imem_req & imem_ready)
- imem_rvalid  in  1  response valid; in order, ≥1 cycle after accept
- imem_rdata  in  16  response instruction word
- stall  in  1  decode cannot accept; hold buffer head
- flush  in  1  decode jump/jumpReg redirect
- willBranch  in  1  decode taken-branch redirect
- nextPC  in  16  redirect target, valid when flush|willBranch
- instr  out  16  instruction to decode (buffer head, or NOP_INSTR)
- PC  out  16  address of instr plus 2 (link/branch base)
- fetch_stall  out  1  1 = instr is a bubble
- halted  out  1  fetch frozen after HALT consumed

Behaviour:
- Reset (rst low, async):
  - fetch_pc=RESET_PC; buffer empty; no request outstanding; squash=0; halted=0.
  - Outputs: imem_req=0, instr=NOP_INSTR, PC=16'h0000, fetch_stall=1.
- State machine:
  - IDLE: first cycle after reset release. Go to RUN.
  - RUN: normal fetching.
  - HALTED: entered when a HALT word (instr[15:11]==5'b00000) is popped to decode. It is terminal until reset.
- Request issue:
  - In RUN, imem_req=1 when there is no outstanding request and count < BUF_DEPTH.
  - imem_addr=fetch_pc.
  - On accept, set the outstanding flag and advance fetch_pc by 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- Response:
  - If imem_rvalid with outstanding=1: clear outstanding.
  - If squash=0, push {imem_rdata, addr+2} into the buffer.
  - If squash=1, drop the word and clear squash.
  - imem_rvalid with no outstanding request is ignored.
- Pop:
  - The head is consumed when count>0, stall=0, and no redirect this cycle.
  - Push and pop in the same cycle are legal and leave count unchanged.
- Outputs (combinational from the buffer head):
  - count>0: instr=head word, PC=head pc+2, fetch_stall=0.
  - count==0: instr=NOP_INSTR, PC holds its last value, fetch_stall=1.
- Redirect (flush|willBranch):
  - fetch_pc<=nextPC; buffer cleared; no pop.
  - If a request is outstanding and its response does not arrive this cycle, set squash=1.
  - A response arriving in the redirect cycle is dropped.
  - A request accepted in the redirect cycle is for the old path; mark it squashed.
  - Redirect overrides stall.
- HALT:
  - On popping a HALT word: go to HALTED, set halted=1, clear the buffer, and squash any in-flight response.
  - In HALTED: imem_req=0, fetch_stall=1; redirects and responses are ignored.
- Full buffer: no request is issued, so there is no overflow. Push to a full buffer is impossible by construction.
- Reset mid-operation: immediately returns to reset values. Any memory response after reset release is ignored (outstanding=0).

Test Plan:
1. Single-cycle memory (response 1 cycle after accept), stall=0, imem words 0x1111, 0x2222, 0x3333 at 0, 2, 4.
   - Required: instr sequence 0x1111, 0x2222, 0x3333 with PC 2, 4, 6; fetch_stall=0 once the pipe is full.
2. Hold stall=1 for 5 cycles with a 1-cycle memory.
   - Required: buffer fills to BUF_DEPTH=2; imem_req drops to 0; instr stays 0x1111.
   - On stall release, 0x2222 follows with nothing lost or duplicated.
3. 3-cycle memory latency, redirect while the request for 0x0004 is outstanding: flush=1, nextPC=0x0040.
   - Required: the late word for 0x0004 is dropped.
   - Next request has imem_addr=0x0040; next valid instr is mem[0x40] with PC=0x0042.
4. willBranch=1, nextPC=0x0100, in the same cycle as imem_rvalid and with stall=1.
   - Required: the arriving word is discarded, the buffer is cleared, and imem_addr=0x0100 next.
5. fetch_pc=0xFFFE.
   - Required: fetch returns mem[0xFFFE] with PC=0x0000; next imem_addr=0x0000.
6. HALT word (0x0000) reaches the buffer head with stall=0.
   - Required: halted=1 the next cycle; imem_req=0 and fetch_stall=1 thereafter, even with flush=1.
   - Assert rst low mid-stream: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one-in-flight request/response to instruction memory,
// a small in-order fetch buffer, redirect squashing and a terminal HALT state.
module fetch_unit #(
  parameter int          BUF_DEPTH = 2,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        willBranch,
  input  logic [15:0] nextPC,
  output logic [15:0] instr,
  output logic [15:0] PC,
  output logic        fetch_stall,
  output logic        halted
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} fetchState;

  fetchState        state, stateNext;
  logic [15:0]      fetchPc, reqPc, pcHold;
  logic             outstanding, squash;
  logic [PTR_W-1:0] headPtr, tailPtr;
  logic [CNT_W-1:0] count;
  logic [15:0]      bufWord [BUF_DEPTH];
  logic [15:0]      bufLink [BUF_DEPTH];

  logic headValid, redirect, accept, rspValid, push, pop, haltPop, bufClear;

  assign headValid   = (count != '0);
  assign accept      = imem_req & imem_ready;
  assign rspValid    = imem_rvalid & outstanding;
  assign bufClear    = redirect | haltPop;
  // A response is dropped when squashed, when it meets a redirect, or outside RUN.
  assign push        = rspValid & ~squash & ~redirect & (state == RUN);
  assign imem_addr   = fetchPc;
  assign instr       = headValid ? bufWord[headPtr] : NOP_INSTR;
  assign PC          = headValid ? bufLink[headPtr] : pcHold;
  assign fetch_stall = ~headValid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    stateNext = state;
    imem_req  = 1'b0;
    halted    = 1'b0;
    redirect  = 1'b0;
    pop       = 1'b0;
    haltPop   = 1'b0;
    unique case (state)
      IDLE: begin
        redirect  = flush | willBranch;
        stateNext = RUN;
      end
      RUN: begin
        imem_req = ~outstanding && (count < FULL_COUNT);
        redirect = flush | willBranch;
        pop      = headValid && !stall && !redirect;
        haltPop  = pop && (bufWord[headPtr][15:11] == 5'b00000);
        if (haltPop) stateNext = HALTED;
      end
      HALTED: halted = 1'b1;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      reqPc       <= RESET_PC;
      pcHold      <= 16'h0000;
      outstanding <= 1'b0;
      squash      <= 1'b0;
      headPtr     <= '0;
      tailPtr     <= '0;
      count       <= '0;
    end else begin
      pcHold <= PC;

      if (redirect)    fetchPc <= nextPC;
      else if (accept) fetchPc <= fetchPc + 16'd2;
      if (accept) reqPc <= fetchPc;

      if (rspValid)    outstanding <= 1'b0;
      else if (accept) outstanding <= 1'b1;

      // An in-flight word not arriving now, or one just accepted, belongs to the old path.
      if (bufClear && ((outstanding && !imem_rvalid) || accept)) squash <= 1'b1;
      else if (rspValid)                                         squash <= 1'b0;

      if (bufClear) begin
        headPtr <= '0;
        tailPtr <= '0;
        count   <= '0;
      end else begin
        if (push) tailPtr <= tailPtr + 1'b1;
        if (pop)  headPtr <= headPtr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  // NOTE: buffer storage has no reset; count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      bufWord[tailPtr] <= imem_rdata;
      bufLink[tailPtr] <= reqPc + 16'd2;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model, and a
// scoreboard of expected {instr, PC} pairs checked whenever decode consumes.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } sbEntry;

  logic        clk;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        willBranch;
  logic [15:0] nextPC;
  logic [15:0] instr;
  logic [15:0] PC;
  logic        fetch_stall;
  logic        halted;

  int passCnt  = 0;
  int failCnt  = 0;
  int totalCnt = 0;

  sbEntry      sbQ[$];
  logic [15:0] memArr [logic [15:0]];
  int          memLat = 1;
  logic        pendValid = 1'b0;
  logic [15:0] pendAddr  = 16'h0000;
  int          pendDelay = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .willBranch (willBranch),
    .nextPC     (nextPC),
    .instr      (instr),
    .PC         (PC),
    .fetch_stall(fetch_stall),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (memArr.exists(a)) return memArr[a];
    return 16'hA000 | {3'b000, a[12:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    totalCnt++;
    assert (obs === expv) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive point: 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic sbPush(input logic [15:0] w, input logic [15:0] p);
    sbEntry e;
    e.word = w;
    e.pc   = p;
    sbQ.push_back(e);
  endtask

  task automatic redirect(input logic isBranch, input logic [15:0] target);
    sbQ.delete();
    nextPC = target;
    if (isBranch) willBranch = 1'b1;
    else          flush      = 1'b1;
    step();
    flush      = 1'b0;
    willBranch = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles && sbQ.size() != 0; i++) step();
    check(tag, sbQ.size(), 0);
  endtask

  task automatic waitReq(input string tag, input logic [15:0] addr, input int maxCycles);
    for (int i = 0; i < maxCycles && !imem_req; i++) step();
    check({tag, "_req"}, imem_req, 1'b1);
    check(tag, imem_addr, addr);
  endtask

  task automatic waitPend(input string tag, input logic [15:0] addr, input int maxCycles);
    for (int i = 0; i < maxCycles && !(pendValid && pendAddr == addr); i++) step();
    check(tag, pendAddr, addr);
  endtask

  task automatic waitRvalid(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles && !imem_rvalid; i++) step();
    check(tag, imem_rvalid, 1'b1);
  endtask

  // Memory model: response decided at the falling edge, acceptance seen after stimulus settles.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pendValid) begin
        if (pendDelay == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memWord(pendAddr);
          pendValid   = 1'b0;
        end else begin
          pendDelay--;
        end
      end
      #3;
      if (imem_req && imem_ready) begin
        pendValid = 1'b1;
        pendAddr  = imem_addr;
        pendDelay = memLat - 1;
      end
    end
  end

  // Consumption monitor: the head is taken at the next rising edge.
  initial begin
    forever begin
      sbEntry expE;
      @(negedge clk);
      #2;
      if (rst && !fetch_stall && !stall && !flush && !willBranch && !halted) begin
        if (sbQ.size() > 0) expE = sbQ.pop_front();
        else                expE = 'x;
        check("sb_instr", instr, expE.word);
        check("sb_pc", PC, expE.pc);
      end
    end
  end

  initial begin
    stall = 1'b0; flush = 1'b0; willBranch = 1'b0; nextPC = 16'h0000; imem_ready = 1'b1;
    memArr[16'h0000] = 16'h1111; memArr[16'h0002] = 16'h2222; memArr[16'h0004] = 16'h3333;
    memArr[16'h0040] = 16'h4A40; memArr[16'h0042] = 16'h4A42;
    memArr[16'h0100] = 16'h5100; memArr[16'h0102] = 16'h5102;
    memArr[16'hFFFE] = 16'h6FFE;
    memArr[16'h0200] = 16'h7200; memArr[16'h0202] = 16'h0000; memArr[16'h0204] = 16'h7204;

    #1 rst = 1'b0;
    repeat (3) step();
    check("rst_req", imem_req, 1'b0);
    check("rst_instr", instr, 16'h0800);
    check("rst_pc", PC, 16'h0000);
    check("rst_fstall", fetch_stall, 1'b1);
    check("rst_halted", halted, 1'b0);

    // 1: single-cycle memory, free-running decode
    sbPush(16'h1111, 16'h0002); sbPush(16'h2222, 16'h0004); sbPush(16'h3333, 16'h0006);
    rst = 1'b1;
    waitDrain("t1_drain", 40);
    stall = 1'b1;

    // 2: stalled decode fills the buffer and stops requests
    repeat (4) step();
    redirect(1'b0, 16'h0000);
    repeat (6) step();
    check("t2_req_off", imem_req, 1'b0);
    check("t2_addr", imem_addr, 16'h0004);
    check("t2_instr", instr, 16'h1111);
    check("t2_pc", PC, 16'h0002);
    check("t2_fstall", fetch_stall, 1'b0);
    sbPush(16'h1111, 16'h0002); sbPush(16'h2222, 16'h0004); sbPush(16'h3333, 16'h0006);
    stall = 1'b0;
    waitDrain("t2_drain", 40);
    stall = 1'b1;

    // 3: flush while the 3-cycle fetch of 0x0004 is in flight
    memLat = 3;
    repeat (8) step();
    redirect(1'b0, 16'h0000);
    sbPush(16'h1111, 16'h0002); sbPush(16'h2222, 16'h0004);
    stall = 1'b0;
    waitDrain("t3_pre_drain", 60);
    stall = 1'b1;
    waitPend("t3_pend", 16'h0004, 20);
    step();
    redirect(1'b0, 16'h0040);
    waitReq("t3_addr", 16'h0040, 20);
    check("t3_dropped", fetch_stall, 1'b1);
    sbPush(16'h4A40, 16'h0042); sbPush(16'h4A42, 16'h0044);
    stall = 1'b0;
    waitDrain("t3_drain", 60);
    stall = 1'b1;

    // 4: taken branch coinciding with a response, under stall
    waitRvalid("t4_rvalid", 20);
    nextPC     = 16'h0100;
    willBranch = 1'b1;
    step();
    willBranch = 1'b0;
    check("t4_fstall", fetch_stall, 1'b1);
    check("t4_instr", instr, 16'h0800);
    check("t4_pc_hold", PC, 16'h0044);
    check("t4_req", imem_req, 1'b1);
    check("t4_addr", imem_addr, 16'h0100);
    sbPush(16'h5100, 16'h0102); sbPush(16'h5102, 16'h0104);
    stall = 1'b0;
    waitDrain("t4_drain", 60);
    stall = 1'b1;

    // 5: PC wraps past 0xFFFE
    memLat = 1;
    repeat (8) step();
    redirect(1'b0, 16'hFFFE);
    waitReq("t5_addr_top", 16'hFFFE, 10);
    step();
    waitReq("t5_addr_wrap", 16'h0000, 10);
    repeat (4) step();
    check("t5_instr", instr, 16'h6FFE);
    check("t5_pc", PC, 16'h0000);
    sbPush(16'h6FFE, 16'h0000); sbPush(16'h1111, 16'h0002);
    stall = 1'b0;
    waitDrain("t5_drain", 40);
    stall = 1'b1;

    // 6: HALT freezes fetch; redirects are ignored afterwards
    repeat (6) step();
    redirect(1'b1, 16'h0200);
    sbPush(16'h7200, 16'h0202); sbPush(16'h0000, 16'h0204);
    stall = 1'b0;
    waitDrain("t6_drain", 40);
    check("t6_halted", halted, 1'b1);
    check("t6_req", imem_req, 1'b0);
    check("t6_fstall", fetch_stall, 1'b1);
    check("t6_instr", instr, 16'h0800);
    nextPC = 16'h0300;
    flush  = 1'b1;
    step();
    flush = 1'b0;
    repeat (3) step();
    check("t6_halted_hold", halted, 1'b1);
    check("t6_req_hold", imem_req, 1'b0);
    check("t6_fstall_hold", fetch_stall, 1'b1);

    // Asynchronous reset out of HALTED
    #4 rst = 1'b0;
    #1;
    check("rst2_halted", halted, 1'b0);
    check("rst2_pc", PC, 16'h0000);
    check("rst2_fstall", fetch_stall, 1'b1);
    step();
    step();
    rst    = 1'b1;
    memLat = 3;
    sbPush(16'h1111, 16'h0002);
    waitDrain("t7_drain", 40);
    stall = 1'b1;

    // Reset with a fetch in flight; the stale response must be ignored
    waitPend("t7_pend", 16'h0002, 20);
    #4 rst = 1'b0;
    #1;
    check("rst3_req", imem_req, 1'b0);
    check("rst3_instr", instr, 16'h0800);
    check("rst3_pc", PC, 16'h0000);
    check("rst3_fstall", fetch_stall, 1'b1);
    imem_ready = 1'b0;
    step();
    rst = 1'b1;
    waitRvalid("t7_stale_rvalid", 10);
    step();
    check("t7_stale_drop", fetch_stall, 1'b1);
    imem_ready = 1'b1;
    sbPush(16'h1111, 16'h0002); sbPush(16'h2222, 16'h0004);
    stall = 1'b0;
    waitDrain("t7_restart", 60);
    stall = 1'b1;
    repeat (2) step();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
